// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means centroid datapath.
// Holds the default geometry (cluster count, dimensionality, coordinate
// and count widths) and the controller state encoding.
package kmeans_pkg;

    localparam int K_DEF       = 4;
    localparam int DIM_DEF     = 7;
    localparam int COORD_W_DEF = 13;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DIV   = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

endpackage

// File: rtl/centroid_accumulator.sv
// centroid_accumulator
// Accumulates per-cluster coordinate sums and point counts over one pass,
// then walks every cluster/dimension through an external combinational
// divider and emits one mean vector per cluster over a valid/ready port.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start, finish       : begin a pass (clears state) / end accumulation
//   pt_valid/pt_ready   : point input handshake
//   pt_cluster, pt_coord: cluster index and packed coordinates (dim 0 in LSBs)
//   div_a, div_b        : dividend / divisor to the external divider
//   div_quotient        : floor(div_a / div_b) from the divider
//   div_by_0            : divider reports a zero divisor
//   cent_valid/ready    : centroid output handshake
//   cent_id, cent_coord : cluster index and packed mean coordinates
//   cent_empty          : cluster had no points (coordinates forced to 0)
//   done                : one-cycle pulse after the last centroid is taken
//   overflow            : sticky, a point was dropped on a saturated count
//
// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting points into sums/counts
// DIV    | dividing sum[k][d] by count[k], one dimension per cycle
// EMIT   | presenting centroid k until accepted
module centroid_accumulator
    import kmeans_pkg::*;
#(
    parameter  int K       = K_DEF,
    parameter  int DIM     = DIM_DEF,
    parameter  int COORD_W = COORD_W_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int SUM_W   = COORD_W + CNT_W,
    localparam int KW      = (K > 1) ? $clog2(K) : 1,
    localparam int DW      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   finish,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    input  logic [KW-1:0]          pt_cluster,
    input  logic [DIM*COORD_W-1:0] pt_coord,
    output logic [SUM_W-1:0]       div_a,
    output logic [CNT_W-1:0]       div_b,
    input  logic [SUM_W-1:0]       div_quotient,
    input  logic                   div_by_0,
    output logic                   cent_valid,
    input  logic                   cent_ready,
    output logic [KW-1:0]          cent_id,
    output logic [DIM*COORD_W-1:0] cent_coord,
    output logic                   cent_empty,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [DW-1:0] D_LAST = DW'(DIM - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    state_e               state_q, state_d;
    logic [SUM_W-1:0]     sum_q  [K][DIM];
    logic [SUM_W-1:0]     sum_d  [K][DIM];
    logic [CNT_W-1:0]     cnt_q  [K];
    logic [CNT_W-1:0]     cnt_d  [K];
    logic [COORD_W-1:0]   cent_q [DIM];
    logic [COORD_W-1:0]   cent_d [DIM];
    logic                 empty_q, empty_d;
    logic [KW-1:0]        k_q, k_d;
    logic [DW-1:0]        d_q, d_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;

    // Only the low COORD_W quotient bits can be a mean of COORD_W-bit values.
    logic unused_quot_hi;
    assign unused_quot_hi = ^div_quotient[SUM_W-1:COORD_W];

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        cent_d   = cent_q;
        empty_d  = empty_q;
        k_d      = k_q;
        d_d      = d_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        valid_d  = 1'b0;
        pt_ready = 1'b0;
        div_a    = '0;
        div_b    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = '{default: '0};
                    cnt_d   = '{default: '0};
                    ovf_d   = 1'b0;
                    k_d     = '0;
                    d_d     = '0;
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                pt_ready = 1'b1;
                // A point arriving with finish is still accumulated, since
                // the sums are updated on the same edge that enters DIV.
                if (pt_valid) begin
                    if (cnt_q[pt_cluster] == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d[pt_cluster] = cnt_q[pt_cluster] + CNT_W'(1);
                        for (int d = 0; d < DIM; d++) begin
                            sum_d[pt_cluster][d] = sum_q[pt_cluster][d]
                                + SUM_W'(pt_coord[d*COORD_W +: COORD_W]);
                        end
                    end
                end
                if (finish) begin
                    k_d     = '0;
                    d_d     = '0;
                    state_d = ST_DIV;
                end
            end

            ST_DIV: begin
                div_a = sum_q[k_q][d_q];
                div_b = cnt_q[k_q];
                cent_d[d_q] = div_by_0 ? '0 : div_quotient[COORD_W-1:0];
                empty_d     = div_by_0;
                if (d_q == D_LAST) begin
                    state_d = ST_EMIT;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end

            ST_EMIT: begin
                // cent_valid is registered, so it rises one cycle after
                // entering EMIT and the emitted fields are already settled.
                if (valid_q && cent_ready) begin
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        d_d     = '0;
                        state_d = ST_DIV;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
            cent_q  <= '{default: '0};
            empty_q <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cent_q  <= cent_d;
            empty_q <= empty_d;
            k_q     <= k_d;
            d_q     <= d_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        cent_coord = '0;
        for (int d = 0; d < DIM; d++) begin
            cent_coord[d*COORD_W +: COORD_W] = cent_q[d];
        end
    end

    assign cent_valid = valid_q;
    assign cent_id    = k_q;
    assign cent_empty = empty_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_centroid_accumulator.sv
module tb_centroid_accumulator;

    localparam int K     = 4;
    localparam int DIM   = 7;
    localparam int CW    = 13;
    localparam int CNTW  = 16;
    localparam int SUMW  = CW + CNTW;
    localparam int CNTWS = 4;
    localparam int SUMWS = CW + CNTWS;
    localparam int PW    = DIM * CW;

    typedef struct {
        logic [1:0]    cluster;
        logic [PW-1:0] coord;
    } pt_t;

    typedef struct {
        logic [1:0]    id;
        logic [PW-1:0] coord;
        logic          empty;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    // default-width instance
    logic            start, finish, pt_valid, pt_ready, div_z;
    logic [1:0]      pt_cluster, cent_id;
    logic [PW-1:0]   pt_coord, cent_coord;
    logic [SUMW-1:0] div_a, div_q;
    logic [CNTW-1:0] div_b;
    logic            cent_valid, cent_ready, cent_empty, done, overflow;

    // narrow-count instance (CNT_W = 4)
    logic             start_s, finish_s, pt_valid_s, pt_ready_s, div_z_s;
    logic [1:0]       pt_cluster_s, cent_id_s;
    logic [PW-1:0]    pt_coord_s, cent_coord_s;
    logic [SUMWS-1:0] div_a_s, div_q_s;
    logic [CNTWS-1:0] div_b_s;
    logic             cent_valid_s, cent_ready_s, cent_empty_s, done_s, overflow_s;

    always #5 clk = ~clk;

    // external combinational floor divider
    assign div_z   = (div_b == '0);
    assign div_q   = div_z ? '0 : div_a / SUMW'(div_b);
    assign div_z_s = (div_b_s == '0);
    assign div_q_s = div_z_s ? '0 : div_a_s / SUMWS'(div_b_s);

    centroid_accumulator #(.K(K), .DIM(DIM), .COORD_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_cluster(pt_cluster), .pt_coord(pt_coord),
        .div_a(div_a), .div_b(div_b), .div_quotient(div_q), .div_by_0(div_z),
        .cent_valid(cent_valid), .cent_ready(cent_ready), .cent_id(cent_id),
        .cent_coord(cent_coord), .cent_empty(cent_empty), .done(done), .overflow(overflow)
    );

    centroid_accumulator #(.K(K), .DIM(DIM), .COORD_W(CW), .CNT_W(CNTWS)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .finish(finish_s),
        .pt_valid(pt_valid_s), .pt_ready(pt_ready_s), .pt_cluster(pt_cluster_s), .pt_coord(pt_coord_s),
        .div_a(div_a_s), .div_b(div_b_s), .div_quotient(div_q_s), .div_by_0(div_z_s),
        .cent_valid(cent_valid_s), .cent_ready(cent_ready_s), .cent_id(cent_id_s),
        .cent_coord(cent_coord_s), .cent_empty(cent_empty_s), .done(done_s), .overflow(overflow_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] splat(input int v);
        logic [PW-1:0] r;
        r = '0;
        for (int d = 0; d < DIM; d++) r[d*CW +: CW] = CW'(v);
        return r;
    endfunction

    pt_t  pts[$];
    exp_t exps[K];
    int   exp3[DIM] = '{4595, 4596, 4596, 4597, 4597, 4598, 4598};

    initial begin
        logic [PW-1:0] pa, e3;
        int cyc, bad;

        rst = 1'b1;
        start = 0; finish = 0; pt_valid = 0; pt_cluster = 0; pt_coord = '0; cent_ready = 0;
        start_s = 0; finish_s = 0; pt_valid_s = 0; pt_cluster_s = 0; pt_coord_s = '0; cent_ready_s = 0;

        // point A of cluster 3: coord[d] = 1000 + d; point B: max coordinate
        pa = '0;
        e3 = '0;
        for (int d = 0; d < DIM; d++) begin
            pa[d*CW +: CW] = CW'(1000 + d);
            e3[d*CW +: CW] = CW'(exp3[d]);
        end
        pts.push_back('{cluster: 2'd0, coord: splat(10)});
        pts.push_back('{cluster: 2'd1, coord: splat(1)});
        pts.push_back('{cluster: 2'd3, coord: pa});
        pts.push_back('{cluster: 2'd1, coord: splat(1)});
        pts.push_back('{cluster: 2'd0, coord: splat(20)});
        pts.push_back('{cluster: 2'd1, coord: splat(2)});
        pts.push_back('{cluster: 2'd3, coord: splat(8191)});
        exps[0] = '{id: 2'd0, coord: splat(15), empty: 1'b0};
        exps[1] = '{id: 2'd1, coord: splat(1),  empty: 1'b0};
        exps[2] = '{id: 2'd2, coord: splat(0),  empty: 1'b1};
        exps[3] = '{id: 2'd3, coord: e3,        empty: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_pt_ready",   128'(pt_ready), 0);
        check("rst_cent_valid", 128'(cent_valid), 0);
        check("rst_done",       128'(done), 0);
        check("rst_overflow",   128'(overflow), 0);
        check("rst_cent_id",    128'(cent_id), 0);
        check("rst_cent_coord", 128'(cent_coord), 0);
        check("rst_cent_empty", 128'(cent_empty), 0);
        check("rst_div_a",      128'(div_a), 0);
        rst = 1'b0;

        // ---------------- main pass ----------------
        @(posedge clk); #1;
        check("idle_pt_ready", 128'(pt_ready), 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("accum_pt_ready", 128'(pt_ready), 1);
        check("accum_div_a",    128'(div_a), 0);

        // last point presented together with finish
        for (int i = 0; i < pts.size(); i++) begin
            pt_valid = 1; pt_cluster = pts[i].cluster; pt_coord = pts[i].coord;
            finish = (i == pts.size() - 1);
            @(posedge clk); #1;
        end
        pt_valid = 0; finish = 0;

        // now in DIV, k=0 d=0: sum 30 over 2 points
        check("div_pt_ready", 128'(pt_ready), 0);
        check("div_a_k0d0",   128'(div_a), 30);
        check("div_b_k0",     128'(div_b), 2);

        cyc = 0;
        while (!cent_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("valid_latency", 128'(cyc), DIM + 1);

        for (int k = 0; k < K; k++) begin
            cyc = 0;
            while (!cent_valid && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("emit_valid", 128'(cent_valid), 1);
            check("emit_id",    128'(cent_id), 128'(exps[k].id));
            check("emit_coord", 128'(cent_coord), 128'(exps[k].coord));
            check("emit_empty", 128'(cent_empty), 128'(exps[k].empty));
            check("emit_div_a_zero", 128'(div_a), 0);
            if (k == 1) begin
                cent_ready = 0;
                bad = 0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    if (cent_valid !== 1'b1 || cent_id !== exps[k].id || cent_coord !== exps[k].coord)
                        bad++;
                end
                check("hold_stable", 128'(bad), 0);
            end
            cent_ready = 1;
            @(posedge clk); #1;
            cent_ready = 0;
            check("post_hs_valid", 128'(cent_valid), 0);
            if (k < K - 1) check("no_early_done", 128'(done), 0);
        end
        check("done_pulse",     128'(done), 1);
        check("pass1_overflow", 128'(overflow), 0);
        @(posedge clk); #1;
        check("done_one_cycle", 128'(done), 0);
        check("idle_again",     128'(pt_ready), 0);

        // ---------------- narrow count: saturation ----------------
        start_s = 1;
        @(posedge clk); #1;
        start_s = 0;
        for (int i = 0; i < 16; i++) begin
            pt_valid_s = 1; pt_cluster_s = 2'd0;
            pt_coord_s = (i < 15) ? splat(i * 10) : splat(8191);
            @(posedge clk); #1;
            if (i == 14) check("ovf_before_16th", 128'(overflow_s), 0);
        end
        pt_valid_s = 0;
        check("ovf_after_16th", 128'(overflow_s), 1);
        finish_s = 1;
        @(posedge clk); #1;
        finish_s = 0;
        for (int k = 0; k < K; k++) begin
            cyc = 0;
            while (!cent_valid_s && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("sat_valid", 128'(cent_valid_s), 1);
            check("sat_id",    128'(cent_id_s), 128'(k));
            check("sat_coord", 128'(cent_coord_s), (k == 0) ? 128'(splat(70)) : 128'(0));
            check("sat_empty", 128'(cent_empty_s), (k == 0) ? 128'(0) : 128'(1));
            cent_ready_s = 1;
            @(posedge clk); #1;
            cent_ready_s = 0;
        end
        check("sat_done",       128'(done_s), 1);
        check("sat_ovf_sticky", 128'(overflow_s), 1);

        // ---------------- reset during DIV ----------------
        start = 1;
        @(posedge clk); #1;
        start = 0;
        pt_valid = 1; pt_cluster = 2'd2; pt_coord = splat(5);
        @(posedge clk); #1;
        pt_valid = 0;
        finish = 1;
        @(posedge clk); #1;
        finish = 0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_pt_ready",   128'(pt_ready), 0);
        check("arst_cent_valid", 128'(cent_valid), 0);
        check("arst_div_a",      128'(div_a), 0);
        check("arst_div_b",      128'(div_b), 0);
        check("arst_done",       128'(done), 0);
        check("arst_cent_id",    128'(cent_id), 0);
        check("arst_cent_coord", 128'(cent_coord), 0);
        check("arst_cent_empty", 128'(cent_empty), 0);
        check("arst_overflow",   128'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cent_ready = 1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (cent_valid || done || pt_ready) bad++;
        end
        cent_ready = 0;
        check("abandoned_pass", 128'(bad), 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("restart_pt_ready", 128'(pt_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/centroid_accumulator.md
CENTROID_ACCUMULATOR -- requirements
Module: centroid_accumulator

Interface
REQ-001 SHALL have parameter K, default 4, meaning number of clusters.
REQ-002 SHALL have parameter DIM, default 7, meaning coordinates per point.
REQ-003 SHALL have parameter COORD_W, default 13, meaning unsigned coordinate width.
REQ-004 SHALL have parameter CNT_W, default 16, meaning per-cluster point-count width; SUM_W = COORD_W+CNT_W.
REQ-005 SHALL have ports clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports start in 1, clear-and-begin pulse; finish in 1, end-of-pass pulse.
REQ-007 SHALL have ports pt_valid in 1; pt_ready out 1; pt_cluster in $clog2(K); pt_coord in DIM*COORD_W, dim 0 in LSBs.
REQ-008 SHALL have ports div_a out SUM_W, dividend; div_b out CNT_W, divisor; div_quotient in SUM_W; div_by_0 in 1 (external combinational divider, same cycle).
REQ-009 SHALL have ports cent_valid out 1; cent_ready in 1; cent_id out $clog2(K); cent_coord out DIM*COORD_W; cent_empty out 1.
REQ-010 SHALL have ports done out 1, one-cycle pulse; overflow out 1, sticky flag.

Function
REQ-011 SHALL implement FSM IDLE, ACCUM, DIV, EMIT.
REQ-012 IDLE: start -> clear all sums, counts, overflow; next ACCUM. start ignored in other states.
REQ-013 ACCUM: pt_ready=1; pt_valid&pt_ready -> sum[pt_cluster][d] += pt_coord[d] for all d; count[pt_cluster] += 1.
REQ-014 ACCUM: finish -> DIV with k=0, d=0; a point presented in the same cycle SHALL be accepted first.
REQ-015 Point arriving when count[pt_cluster] is all-ones SHALL be dropped (sums, count unchanged) and set overflow.
REQ-016 DIV: div_a = sum[k][d], div_b = count[k]; capture low COORD_W bits of div_quotient into centroid reg d each cycle; d increments.
REQ-017 DIV: after d=DIM-1 captured -> EMIT; cent_valid rises DIM+1 edges after the edge sampling finish.
REQ-018 div_by_0 (count 0) SHALL force captured coordinate 0 and cent_empty=1 for that cluster.
REQ-019 EMIT: cent_valid=1, cent_id=k, cent_coord, cent_empty held stable until cent_valid&cent_ready.
REQ-020 EMIT handshake with k<K-1 -> k+1, d=0, DIV; with k=K-1 -> IDLE, done=1 for one cycle.
REQ-021 Quotient SHALL be truncating unsigned division (floor).
REQ-022 pt_ready SHALL be 0 outside ACCUM; div_a, div_b SHALL be 0 outside DIV.

Reset
REQ-023 rst SHALL asynchronously force IDLE; sums, counts, centroid regs, k, d to 0; pt_ready, cent_valid, cent_empty, done, overflow to 0; cent_id 0.
REQ-024 rst mid-ACCUM/DIV/EMIT SHALL abandon the pass; no cent_valid or done until a new start.

Structure
REQ-025 Shared package kmeans_pkg SHALL hold default K, DIM, COORD_W, CNT_W and the FSM state enum.
REQ-026 No sub-module; divider instantiated by parent and connected via div_* ports.

Verification
REQ-027 Two points cluster 0, all coords 10 then 20, finish -> cent_id 0, all coords 15, cent_empty 0.
REQ-028 Three points cluster 1, coords 1,1,2 -> coord 1 (4/3 truncated).
REQ-029 No points cluster 2 -> cent_id 2, coords 0, cent_empty 1; K=4 outputs, then done pulse.
REQ-030 cent_ready low 5 cycles in EMIT -> cent_valid, cent_id, cent_coord stable; advance on ready.
REQ-031 CNT_W=4, 16 points cluster 0 -> 16th dropped, overflow 1, mean over 15 points.
REQ-032 rst asserted during DIV -> all outputs 0 immediately; start required for next pass.
